rapid_lsu: RTL
==============

# rapid_lsu

Load/store unit for the rapid pipeline. It sits directly downstream of the execute stage and feeds writeback. It turns one memory operation per pipeline advance into a single request/acknowledge transaction on the data bus, and handles byte/halfword alignment, byte enables and load sign/zero extension. It drops its done flag while a bus transaction is outstanding, which stalls the global `pipeline_ready`.

## Interface
Parameters:
- `XLEN`, 32, datapath and address width; only 32 is supported.
- `TIMEOUT_CYCLES`, 255, maximum number of wait cycles for `i_bus_ack` before the transaction is aborted; range 1..255.

Ports:
- `i_clk`  in  1  the single clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pipeline_ready`  in  1  global advance strobe.
- `i_valid`  in  1  an operation is presented.
- `i_mem_read`  in  1  the operation is a load.
- `i_mem_write`  in  1  the operation is a store.
- `i_funct3`  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_address`  in  XLEN  byte address from execute.
- `i_store_data`  in  XLEN  store data; its low bits are used per access size.
- `i_rd`  in  5  destination register.
- `o_bus_req`  out  1  bus request; held high until acknowledged.
- `o_bus_we`  out  1  1 = write.
- `o_bus_addr`  out  XLEN  word-aligned address, i.e. `{i_address[XLEN-1:2], 2'b00}`.
- `o_bus_be`  out  4  byte enables.
- `o_bus_wdata`  out  XLEN  lane-replicated write data.
- `i_bus_ack`  in  1  acknowledge; a single-cycle pulse.
- `i_bus_rdata`  in  XLEN  read data, valid in the cycle `i_bus_ack` is high.
- `o_load_data`  out  XLEN  extended load result; 0 when the operation was not a completed load.
- `o_rd`  out  5  registered copy of `i_rd`.
- `o_rd_we`  out  1  writeback enable.
- `o_misaligned`  out  1  the last operation was misaligned or used an illegal `funct3`.
- `o_bus_error`  out  1  the last transaction timed out.
- `o_done`  out  1  the unit is idle and its outputs are valid.

## Operation
- States: IDLE and BUSY. `o_done` = (state == IDLE).
- Accept condition: state IDLE, `i_pipeline_ready`=1 and `i_valid`=1. On accept, `o_rd` is latched and `o_misaligned`, `o_bus_error` and `o_rd_we` are cleared before the new result is applied.
- Neither read nor write: stay in IDLE. `o_load_data`=0, `o_rd_we`=0.
- Misaligned or illegal access: set `o_misaligned`, issue no bus request, stay in IDLE, `o_rd_we`=0.
  - Misaligned means H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0.
  - Illegal means any load `funct3` outside {000, 001, 010, 100, 101}, or any store `funct3` outside {000, 001, 010}.
  - Read and write both set counts as illegal.
- Legal access: go to BUSY and drive `o_bus_req`=1 along with the address, write enable, byte enables and write data.
- Byte enables and write data:
  - SB: be = `4'b0001 << addr[1:0]`; wdata = store byte ×4.
  - SH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = store half ×2.
  - SW: be = 1111; wdata = store data.
  - Loads: be is the same pattern for the access size; wdata = 0.
- In BUSY, `i_bus_ack`=1: capture and shift `i_bus_rdata` right by 8·`addr[1:0]`, then extend:
  - B: sign-extend bit 7.
  - BU: zero-extend bit 7.
  - H: sign-extend bit 15.
  - HU: zero-extend bit 15.
  - W: unchanged.
  
  For a load, set `o_rd_we`=1 (also when rd = 0; writeback discards x0). Then return to IDLE and drop `o_bus_req`.
- Timeout: an 8-bit counter clears on entering BUSY and increments each BUSY cycle without ack. When the counter = `TIMEOUT_CYCLES` and there is no ack, set `o_bus_error`=1, `o_rd_we`=0, `o_load_data`=0, and return to IDLE.
- An `i_bus_ack` seen in IDLE is ignored.

## Timing
- Reset values: state IDLE, `o_done`=1. `o_bus_req`, `o_bus_we`, `o_rd_we`, `o_misaligned` and `o_bus_error` are 0. Address, be, wdata, `o_load_data`, `o_rd` and the counter are 0.
- Asserting reset mid-transaction drops `o_bus_req` immediately, abandons the transaction and returns the unit to IDLE.
- Accept at edge N: `o_bus_req` is high from N+1.
- Ack sampled at edge M: from M+1, `o_bus_req`=0, `o_done`=1 and the result outputs are valid. Zero-wait latency (ack in the first BUSY cycle) is 2 edges from accept to done.
- Non-memory, misaligned and illegal operations: results are valid at N+1, and `o_done` never falls.
- Timeout: `o_done` rises `TIMEOUT_CYCLES`+1 cycles after BUSY entry.
- Result outputs hold until the next accept. `o_rd_we` is level, not a pulse; writeback qualifies it with `i_pipeline_ready`.
- Address, enables and data are stable for the whole time `o_bus_req` is high.

## Test plan
- Reset, then SW: addr 0x104, data 0xDEADBEEF, ack after 3 cycles. Required: be 1111, bus addr 0x104, `o_done` low for 4 cycles, `o_rd_we`=0.
- LB: addr 0x203, rdata 0x80FF_1234, zero-wait ack. Required: `o_load_data`=0xFFFFFF80, `o_rd_we`=1, `o_rd` as issued. LBU at the same address returns 0x00000080.
- SH: addr 0x302, data 0x0000ABCD. Required: be 1100, wdata 0xABCDABCD. LHU at addr 0x302 with rdata 0x7F01_0000 returns 0x00007F01.
- LW at addr 0x101. Required: `o_misaligned`=1, `o_bus_req` stays 0, `o_done` stays 1. The next legal op clears the flag.
- No ack with `TIMEOUT_CYCLES`=4. Required: `o_bus_error`=1 and `o_done` rising 5 cycles after BUSY entry. A later ack pulse in IDLE changes nothing.
- Reset asserted in the 2nd BUSY cycle. Required: `o_bus_req` drops without waiting for a clock edge, all outputs return to their reset values, and the next LW completes normally.

Source files
------------

// File: rtl/rapid_lsu.sv
// Load/store unit: one request/acknowledge bus transaction per accepted memory op,
// with sub-word alignment, byte enables, load extension and an ack timeout.
module rapid_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pipeline_ready,
  input  logic            i_valid,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_address,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_be,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_misaligned,
  output logic            o_bus_error,
  output logic            o_done
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t          r_state, w_next;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_bus_addr, r_wdata, r_load_data;
  logic [3:0]      r_be;
  logic            r_we, r_rd_we, r_misaligned, r_bus_error;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [4:0]      r_rd;

  logic            w_accept, w_is_mem, w_illegal, w_misalign, w_fault, w_issue, w_timeout;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_shifted, w_ext;

  always_comb begin
    w_accept   = (r_state == S_IDLE) && i_pipeline_ready && i_valid;
    w_is_mem   = i_mem_read | i_mem_write;
    w_illegal  = i_mem_read & i_mem_write;
    if (i_mem_read && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111))
      w_illegal = 1'b1;
    if (i_mem_write && i_funct3 > 3'b010)
      w_illegal = 1'b1;
    w_misalign = ((i_funct3[1:0] == 2'b01) && i_address[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_address[1:0] != 2'b00));
    w_fault    = w_is_mem & (w_illegal | w_misalign);
    w_issue    = w_accept & w_is_mem & ~w_fault;

    case (i_funct3[1:0])
      2'b00:   w_be = 4'b0001 << i_address[1:0];
      2'b01:   w_be = i_address[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase

    w_wdata = '0;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00:   w_wdata = {4{i_store_data[7:0]}};
        2'b01:   w_wdata = {2{i_store_data[15:0]}};
        default: w_wdata = i_store_data;
      endcase
    end

    w_timeout = (r_state == S_BUSY) && !i_bus_ack && (r_cnt == LP_TIMEOUT);

    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_BUSY;
      S_BUSY:  if (i_bus_ack || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Selected lane moves to bit 0, then extends according to the captured size.
    w_shifted = i_bus_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bus_addr   <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_be         <= '0;
      r_we         <= 1'b0;
      r_rd_we      <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_rd         <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rd         <= i_rd;
        r_misaligned <= w_fault;
        r_bus_error  <= 1'b0;
        r_rd_we      <= 1'b0;
        r_load_data  <= '0;
        if (w_issue) begin
          r_bus_addr <= {i_address[XLEN-1:2], 2'b00};
          r_be       <= w_be;
          r_wdata    <= w_wdata;
          r_we       <= i_mem_write;
          r_funct3   <= i_funct3;
          r_off      <= i_address[1:0];
          r_cnt      <= '0;
        end
      end else if (r_state == S_BUSY) begin
        if (i_bus_ack) begin
          if (!r_we) begin
            r_load_data <= w_ext;
            r_rd_we     <= 1'b1;
          end
        end else if (w_timeout) begin
          r_bus_error <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign o_bus_req    = (r_state == S_BUSY);
  assign o_done       = (r_state == S_IDLE);
  assign o_bus_we     = r_we;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_be     = r_be;
  assign o_bus_wdata  = r_wdata;
  assign o_load_data  = r_load_data;
  assign o_rd         = r_rd;
  assign o_rd_we      = r_rd_we;
  assign o_misaligned = r_misaligned;
  assign o_bus_error  = r_bus_error;

endmodule
